// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one completed result per cycle and broadcasts it on a registered CDB.
// Optional macro CDB_BRANCH_PRIO_EN gives unit 0 (branch unit) fixed highest priority over the round-robin units.
module cdb_arbiter #(
    parameter int          NUM_REQ = 4,
    parameter int          TAG_W   = 5,
    parameter int          DATA_W  = 32,
    parameter int unsigned NO_TAG  = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_index,
    output logic [DATA_W-1:0]           cdb_result,
    output logic                        tag_err
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [TAG_W-1:0] IDLE_TAG = TAG_W'(NO_TAG);
`ifdef CDB_BRANCH_PRIO_EN
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(1);
`else
    localparam logic [PTR_W-1:0] PTR_RST = PTR_W'(0);
`endif

    logic [PTR_W-1:0]   ptr_r;
    logic [PTR_W-1:0]   ptr_nxt_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic               grant_any_s;
    logic [NUM_REQ-1:0] grant_s;
    logic [TAG_W-1:0]   sel_tag_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               cdb_valid_r;
    logic [TAG_W-1:0]   cdb_index_r;
    logic [DATA_W-1:0]  cdb_result_r;
    logic               tag_err_r;

    // Pick the first valid requester at or after ptr; reset and flush block any grant.
    always_comb begin
        int   idx_v;
        int   base_v;
        logic hit_v;
        idx_v       = 0;
        base_v      = 0;
        hit_v       = 1'b0;
        grant_idx_s = '0;
        grant_any_s = 1'b0;
        if (rst && !flush) begin
`ifdef CDB_BRANCH_PRIO_EN
            if (req_valid[0]) begin
                grant_any_s = 1'b1;
                grant_idx_s = '0;
            end else begin
                base_v = (ptr_r == '0) ? 0 : int'(ptr_r) - 1;
                for (int k = 0; k < NUM_REQ - 1; k++) begin
                    idx_v       = 1 + ((base_v + k) % (NUM_REQ - 1));
                    hit_v       = !grant_any_s && req_valid[idx_v];
                    grant_idx_s = hit_v ? PTR_W'(idx_v) : grant_idx_s;
                    grant_any_s = grant_any_s | hit_v;
                end
            end
`else
            base_v = int'(ptr_r);
            for (int k = 0; k < NUM_REQ; k++) begin
                idx_v       = (base_v + k) % NUM_REQ;
                hit_v       = !grant_any_s && req_valid[idx_v];
                grant_idx_s = hit_v ? PTR_W'(idx_v) : grant_idx_s;
                grant_any_s = grant_any_s | hit_v;
            end
`endif
        end else begin
            grant_any_s = 1'b0;
        end
    end

    assign grant_s   = grant_any_s ? (NUM_REQ'(1) << grant_idx_s) : NUM_REQ'(0);
    assign req_ready = grant_s;

    // Mux the granted unit's tag and data using the one-hot grant.
    always_comb begin
        sel_tag_s  = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_tag_s  = grant_s[i] ? req_tag[i*TAG_W +: TAG_W]    : sel_tag_s;
            sel_data_s = grant_s[i] ? req_data[i*DATA_W +: DATA_W] : sel_data_s;
        end
    end

    // Advance ptr past the winner; with branch priority unit 0 never moves it and ptr skips 0.
    always_comb begin
        logic [PTR_W-1:0] wrap_v;
        wrap_v    = (int'(grant_idx_s) == NUM_REQ - 1) ? PTR_W'(0) : grant_idx_s + PTR_W'(1);
        ptr_nxt_s = ptr_r;
        if (grant_any_s) begin
`ifdef CDB_BRANCH_PRIO_EN
            if (grant_idx_s == PTR_W'(0)) begin
                ptr_nxt_s = ptr_r;
            end else if (wrap_v == PTR_W'(0)) begin
                ptr_nxt_s = PTR_W'(1);
            end else begin
                ptr_nxt_s = wrap_v;
            end
`else
            ptr_nxt_s = wrap_v;
`endif
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Broadcast register, pointer and sticky tag error; a NO_TAG winner drains without broadcasting.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r        <= PTR_RST;
            cdb_valid_r  <= 1'b0;
            cdb_index_r  <= IDLE_TAG;
            cdb_result_r <= '0;
            tag_err_r    <= 1'b0;
        end else begin
            ptr_r <= ptr_nxt_s;
            if (grant_any_s && (sel_tag_s != IDLE_TAG)) begin
                cdb_valid_r  <= 1'b1;
                cdb_index_r  <= sel_tag_s;
                cdb_result_r <= sel_data_s;
                tag_err_r    <= tag_err_r;
            end else begin
                cdb_valid_r  <= 1'b0;
                cdb_index_r  <= IDLE_TAG;
                cdb_result_r <= '0;
                tag_err_r    <= tag_err_r | grant_any_s;
            end
        end
    end

    assign cdb_valid  = cdb_valid_r;
    assign cdb_index  = cdb_index_r;
    assign cdb_result = cdb_result_r;
    assign tag_err    = tag_err_r;

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter that shares the single common data bus (CDB) among the out-of-order execution units: ALU, branch unit, load/store and so on. Each unit presents a completed result with its reservation-station tag. The arbiter grants at most one per cycle and broadcasts the winner on a registered CDB. The PC, register file and reservation stations all snoop that CDB to release locks.

## Interface
- NUM_REQ, 4: number of requesting units, from 2 to 8.
- TAG_W, 5: tag width, equal to the register-lock width.
- DATA_W, 32: result width, equal to the instruction-address width.
- NO_TAG, 0: tag value meaning "no lock". It is driven on an idle bus.

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: reset, synchronous, active-low.
- flush  in  1: pipeline flush, for example on a mispredict. It cancels the current grant and the pending broadcast.
- req_valid  in  NUM_REQ: unit i has a result ready.
- req_tag  in  NUM_REQ*TAG_W: tag of unit i, in slice i.
- req_data  in  NUM_REQ*DATA_W: result of unit i, in slice i.
- req_ready  out  NUM_REQ: one-hot or zero grant. It is combinational.
- cdb_valid  out  1: broadcast valid this cycle.
- cdb_index  out  TAG_W: broadcast tag. It is NO_TAG when idle.
- cdb_result  out  DATA_W: broadcast data. It is 0 when idle.
- tag_err  out  1: sticky flag. It is set when a valid request carrying NO_TAG is accepted.

## Operation
- Handshake: a transfer occurs on a cycle where req_valid[i] and req_ready[i] are both high.
  - A unit holds valid, tag and data stable until it is granted.
  - A unit may not withdraw valid before it is granted.
- Grant:
  - req_ready has at most one bit set.
  - It is 0 when no request is valid, when flush=1, or when rst=0.
- Round-robin:
  - A pointer ptr (log2 NUM_REQ bits) selects the first valid requester at or after ptr, searching modulo NUM_REQ.
  - After a grant to unit i, ptr becomes (i+1) mod NUM_REQ.
  - With no grant, ptr is unchanged.
- Broadcast register:
  - On a transfer, the next cycle drives cdb_valid=1, cdb_index=req_tag[i] and cdb_result=req_data[i].
  - On any other cycle the next cycle is idle: cdb_valid=0, cdb_index=NO_TAG, cdb_result=0.
- NO_TAG request:
  - It is granted normally, so the unit drains.
  - The broadcast is suppressed: the output stays idle.
  - tag_err is set to 1 and stays set until reset.
- Flush:
  - In the flush cycle, req_ready=0 and the output register loads idle.
  - A broadcast already on the bus in the flush cycle completes unchanged.
  - ptr is unchanged.
- Reset (rst=0 at a clock edge):
  - ptr=0, output idle, tag_err=0.
  - Any pending broadcast is lost.

## Timing
- Latency: the broadcast appears exactly 1 cycle after the handshake cycle.
- Throughput: 1 broadcast per cycle. Back-to-back grants have no bubble.
- Fairness: without the priority macro, a continuously valid requester is granted within NUM_REQ cycles.
- Reset values: req_ready=0 and cdb_valid=0 during reset. The cycle after reset also drives cdb_index=NO_TAG, cdb_result=0, tag_err=0.
- Simultaneous events:
  - rst=0 dominates flush.
  - flush dominates all requests.
  - When all NUM_REQ units are valid, grants rotate i, i+1, … in consecutive cycles.

## Configuration
- CDB_BRANCH_PRIO_EN: unit 0, the branch unit, has fixed highest priority, so PC redirects resolve first.
  - Defined:
    - When req_valid[0]=1, unit 0 wins regardless of ptr, and ptr is not updated.
    - Otherwise, round-robin runs over units 1..NUM_REQ-1, and ptr never points at 0.
    - The fairness bound applies only to units 1..NUM_REQ-1, and only while unit 0 is idle.
  - Undefined: plain round-robin over all units, as described above.

## Test plan
All scenarios use NUM_REQ=4 and NO_TAG=0.
- Single requester: after reset, unit 2 requests tag 5, data 0x40 → req_ready=4'b0100 in that cycle; next cycle cdb_valid=1, cdb_index=5, cdb_result=0x40; the following cycle is idle with index 0.
- Rotation, macro off: all four units request continuously with tags 1–4 → broadcasts with tags 1,2,3,4,1 on consecutive cycles, no bubbles.
- Flush: units 1 and 3 request, flush=1 for one cycle → no grant that cycle; the bus is idle the next cycle; then unit 1 is granted; ptr is unchanged.
- Invalid tag: unit 0 requests tag 0, data 0xFF → granted; the bus stays idle; tag_err=1 and remains 1 until reset.
- Reset mid-stream: rst=0 while a broadcast is pending → the next cycle is idle with tag_err=0; after release, the first grant goes to the lowest valid unit.
- Priority, macro on: unit 0 requests continuously with units 1–3 → unit 0 wins every cycle; when unit 0 drops, grants rotate 1,2,3.
